// File: rtl/dlf_gain_ctrl.sv
// -----------------------------------------------------------------------------
// dlf_gain_ctrl
// Gain-scheduling lock controller for the bang-bang PLL digital loop filter.
// Measures the toggle density of the phase-detector bit over fixed windows. It
// starts with a high proportional gain (ACQ), halves the gain after every run
// of good windows (SETTLE) and holds the low gain once locked (LOCK). A run of
// bad windows sends it back to acquisition.
//
// Optional feature macro: DLF_GAIN_RUNLEN_EN
//   When defined, a toggle-free run counter (parameter RUN_MAX) is compiled in.
//   RUN_MAX quiet cycles while in SETTLE or LOCK force an immediate return to
//   ACQ without waiting for the window to end.
//
// Ports:
//   clk      in   loop clock (same clock as the loop filter)
//   rst      in   synchronous, active-high reset
//   in       in   bang-bang PFD output bit
//   Kp       out  8-bit proportional gain to the loop filter (registered)
//   locked   out  high while in LOCK (registered)
//   state    out  ACQ=0, SETTLE=1, LOCK=2 (registered)
//   win_done out  one-cycle pulse in the first cycle after each window
// -----------------------------------------------------------------------------
module dlf_gain_ctrl #(
  parameter int unsigned WIN_LEN  = 64,
  parameter int unsigned TOG_MIN  = 16,
  parameter logic [7:0]  KP_MAX   = 8'd128,
  parameter logic [7:0]  KP_MIN   = 8'd8,
  parameter int unsigned GOOD_WIN = 4,
  parameter int unsigned BAD_WIN  = 2
`ifdef DLF_GAIN_RUNLEN_EN
  ,
  parameter int unsigned RUN_MAX  = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic [7:0] Kp,
  output logic       locked,
  output logic [1:0] state,
  output logic       win_done
);

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCK   = 2'd2,
    ST_ILL    = 2'd3
  } state_e;

  localparam int unsigned     WW       = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WW-1:0]   WIN_LAST = WW'(WIN_LEN - 1);
  localparam logic [WW-1:0]   WIN_ONE  = WW'(1);
  localparam logic [WW-1:0]   WIN_ZERO = {WW{1'b0}};
  localparam logic [8:0]      TOG_THR  = 9'(TOG_MIN);
  localparam logic [7:0]      GOOD_THR = 8'(GOOD_WIN);
  localparam logic [7:0]      BAD_THR  = 8'(BAD_WIN);

  // Saturating increment used by the window bookkeeping counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    kp_q, kp_d;
  logic          locked_q, locked_d;
  logic          win_done_q, win_done_d;
  logic          prev_q, prev_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [8:0]    tog_cnt_q, tog_cnt_d;
  logic [7:0]    good_cnt_q, good_cnt_d;
  logic [7:0]    bad_cnt_q, bad_cnt_d;

  logic          tog_s;
  logic          win_end_s;
  logic [8:0]    tog_sum_s;
  logic          good_win_s;
  logic [7:0]    good_nx_s;
  logic [7:0]    bad_nx_s;
  logic          fast_s;

  assign tog_s     = in ^ prev_q;
  assign win_end_s = (win_cnt_q == WIN_LAST);

`ifdef DLF_GAIN_RUNLEN_EN
  localparam int unsigned   RW       = $clog2(RUN_MAX + 1);
  localparam logic [RW-1:0] RUN_THR  = RW'(RUN_MAX);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);
  localparam logic [RW-1:0] RUN_ZERO = {RW{1'b0}};

  logic [RW-1:0] run_cnt_q, run_cnt_d, run_nx_s;

  // Quiet-run length; fires on the edge that completes RUN_MAX quiet cycles.
  always_comb begin
    if (tog_s) begin
      run_nx_s = RUN_ZERO;
    end else if (run_cnt_q == RUN_THR) begin
      run_nx_s = run_cnt_q;
    end else begin
      run_nx_s = run_cnt_q + RUN_ONE;
    end
    if (((state_q == ST_SETTLE) || (state_q == ST_LOCK)) && (run_nx_s == RUN_THR)) begin
      fast_s = 1'b1;
    end else begin
      fast_s = 1'b0;
    end
    if (fast_s) begin
      run_cnt_d = RUN_ZERO;
    end else begin
      run_cnt_d = run_nx_s;
    end
  end

  // Run counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= RUN_ZERO;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end
`else
  assign fast_s = 1'b0;
`endif

  // Window statistics: the toggle of the window's last cycle is included.
  always_comb begin
    if (tog_cnt_q == 9'h1FF) begin
      tog_sum_s = tog_cnt_q;
    end else begin
      tog_sum_s = tog_cnt_q + {8'd0, tog_s};
    end
    good_win_s = (tog_sum_s >= TOG_THR);
    if (good_win_s) begin
      good_nx_s = sat_inc8(good_cnt_q, GOOD_THR);
      bad_nx_s  = 8'd0;
    end else begin
      good_nx_s = 8'd0;
      bad_nx_s  = sat_inc8(bad_cnt_q, BAD_THR);
    end
  end

  // Next-state, gain schedule and counter updates.
  always_comb begin
    prev_d     = in;
    state_d    = state_q;
    kp_d       = kp_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    win_done_d = 1'b0;
    if (win_end_s) begin
      win_cnt_d = WIN_ZERO;
      tog_cnt_d = 9'd0;
    end else begin
      win_cnt_d = win_cnt_q + WIN_ONE;
      tog_cnt_d = tog_sum_s;
    end

    if (fast_s) begin
      // Fast unlock beats a coinciding window evaluation and restarts the window.
      state_d    = ST_ACQ;
      kp_d       = KP_MAX;
      win_cnt_d  = WIN_ZERO;
      tog_cnt_d  = 9'd0;
      good_cnt_d = 8'd0;
      bad_cnt_d  = 8'd0;
    end else if (state_q == ST_ILL) begin
      state_d    = ST_ACQ;
      kp_d       = KP_MAX;
      good_cnt_d = 8'd0;
      bad_cnt_d  = 8'd0;
      win_done_d = win_end_s;
    end else if (win_end_s) begin
      win_done_d = 1'b1;
      good_cnt_d = good_nx_s;
      bad_cnt_d  = bad_nx_s;
      case (state_q)
        ST_ACQ: begin
          if (good_nx_s == GOOD_THR) begin
            good_cnt_d = 8'd0;
            if (KP_MAX == KP_MIN) begin
              state_d = ST_LOCK;
              kp_d    = KP_MIN;
            end else begin
              state_d = ST_SETTLE;
              kp_d    = {1'b0, KP_MAX[7:1]};
            end
          end else begin
            kp_d = KP_MAX;
          end
        end
        ST_SETTLE: begin
          if (good_nx_s == GOOD_THR) begin
            good_cnt_d = 8'd0;
            if (kp_q == KP_MIN) begin
              state_d = ST_LOCK;
            end else begin
              kp_d = {1'b0, kp_q[7:1]};
            end
          end else if (bad_nx_s == BAD_THR) begin
            state_d    = ST_ACQ;
            kp_d       = KP_MAX;
            good_cnt_d = 8'd0;
            bad_cnt_d  = 8'd0;
          end else begin
            kp_d = kp_q;
          end
        end
        ST_LOCK: begin
          if (bad_nx_s == BAD_THR) begin
            state_d    = ST_ACQ;
            kp_d       = KP_MAX;
            good_cnt_d = 8'd0;
            bad_cnt_d  = 8'd0;
          end else begin
            kp_d = KP_MIN;
          end
        end
        default: begin
          state_d = ST_ACQ;
          kp_d    = KP_MAX;
        end
      endcase
    end else begin
      win_done_d = 1'b0;
    end
    locked_d = (state_d == ST_LOCK);
  end

  // State, output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACQ;
      kp_q       <= KP_MAX;
      locked_q   <= 1'b0;
      win_done_q <= 1'b0;
      prev_q     <= 1'b0;
      win_cnt_q  <= WIN_ZERO;
      tog_cnt_q  <= 9'd0;
      good_cnt_q <= 8'd0;
      bad_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      kp_q       <= kp_d;
      locked_q   <= locked_d;
      win_done_q <= win_done_d;
      prev_q     <= prev_d;
      win_cnt_q  <= win_cnt_d;
      tog_cnt_q  <= tog_cnt_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign Kp       = kp_q;
  assign locked   = locked_q;
  assign state    = state_q;
  assign win_done = win_done_q;

endmodule

// File: doc/dlf_gain_ctrl.md
# dlf_gain_ctrl

Gain-scheduling lock controller for the bang-bang PLL digital loop filter. It watches the phase-detector bit that drives the loop filter and measures toggle density over fixed windows. It drives the filter's 8-bit proportional gain `Kp`: high gain during acquisition, halving in steps as the loop settles, low gain once locked. It falls back to acquisition on loss of lock, and sits beside the loop filter, sharing its clock and PFD input.

## Interface
- `WIN_LEN`, 64 — cycles per observation window (2..256).
- `TOG_MIN`, 16 — a window with at least this many `in` toggles is "good"; fewer is "bad".
- `KP_MAX`, 8'd128 — acquisition gain. Must be a power of two.
- `KP_MIN`, 8'd8 — tracking gain. Must be a power of two and ≤ `KP_MAX`.
- `GOOD_WIN`, 4 — consecutive good windows per gain step.
- `BAD_WIN`, 2 — consecutive bad windows that force re-acquisition.
- `RUN_MAX`, 32 — toggle-free run length for fast unlock (only with the macro).
- `clk`  input  1  — loop clock, same clock as the loop filter.
- `rst`  input  1  — synchronous, active-high reset.
- `in`  input  1  — bang-bang PFD output; the same bit the loop filter consumes.
- `Kp`  output  8  — proportional gain to the loop filter; registered.
- `locked`  output  1  — high while in state LOCK; registered.
- `state`  output  2  — ACQ=0, SETTLE=1, LOCK=2.
- `win_done`  output  1  — one-cycle pulse per completed window.

## Operation
- Toggle detect: `prev` register (reset 0). Toggle = `in ^ prev`, evaluated every cycle, so the first cycle after reset counts a toggle if `in`=1.
- Window counter `win_cnt` counts 0..WIN_LEN-1.
- Toggle counter is 9 bits and saturates. It includes the toggle in the window's last cycle.
- At the end of a window both counters clear and the next window starts with no gap.
- Good/bad bookkeeping:
  - `good_cnt` counts consecutive good windows and clears on any bad window.
  - `bad_cnt` counts consecutive bad windows and clears on any good window.
- State ACQ:
  - `Kp`=KP_MAX.
  - When `good_cnt` reaches GOOD_WIN: `Kp`←KP_MAX>>1 and go to SETTLE. If KP_MAX==KP_MIN, go directly to LOCK instead.
  - `good_cnt` clears.
  - Bad windows never leave ACQ.
- State SETTLE:
  - When `good_cnt` reaches GOOD_WIN: if `Kp`==KP_MIN go to LOCK, else `Kp`←`Kp`>>1. `good_cnt` clears in both cases.
  - When `bad_cnt` reaches BAD_WIN: go to ACQ with `Kp`=KP_MAX; all counters clear.
- State LOCK:
  - `Kp` holds at KP_MIN and `locked`=1.
  - When `bad_cnt` reaches BAD_WIN: go to ACQ with `Kp`=KP_MAX and `locked`=0; counters clear.
- Encoding 3 is illegal. It recovers to ACQ with `Kp`=KP_MAX on the next clock.
- Reset values:
  - Outputs: `Kp`=KP_MAX, `state`=ACQ, `locked`=0, `win_done`=0.
  - Internal: all counters and `prev` = 0.

## Timing
- Window N covers WIN_LEN cycles. The evaluation edge is the clock edge that ends cycle WIN_LEN-1.
- New `Kp`, `state`, `locked` and a `win_done`=1 pulse are all visible in the first cycle of window N+1, i.e. one cycle after the last sampled `in`.
- `Kp` changes only at window boundaries, except on fast unlock.
- Fast unlock (macro enabled):
  - Trigger: the run counter reaches RUN_MAX while in SETTLE or LOCK.
  - On the next edge: ACQ, `Kp`=KP_MAX, `locked`=0, window and all counters restart at 0, `win_done` not pulsed.
  - It takes precedence over a window evaluation on the same edge.
- `rst` mid-window or mid-SETTLE: all state returns to reset values on that edge. The partial window is discarded.
- `rst` overrides every other event.

## Configuration
- `DLF_GAIN_RUNLEN_EN` defined:
  - A toggle-free run counter is compiled in. It saturates at RUN_MAX and clears on any toggle.
  - It provides the fast unlock described under Timing.
- Undefined:
  - No run counter and no RUN_MAX logic.
  - Unlock happens only through BAD_WIN consecutive bad windows.

## Test plan
- Defaults, `in` alternating every cycle (64 toggles/window) from reset:
  - `Kp` steps 128→64→32→16→8 at cycles 256, 512, 768, 1024.
  - `locked`=1 and `state`=2 at cycle 1280.
  - `win_done` pulses every 64 cycles.
- Threshold boundary: `in` pattern giving exactly 16 toggles/window → good (advances). 15 toggles/window → bad; `Kp` stays 128 and `state` stays 0 indefinitely.
- Locked, then `in` held at 1:
  - With the macro: `state`=0, `Kp`=128 exactly 33 cycles after the last toggle.
  - Without the macro: `state`=0 at the end of the 2nd bad window.
- In SETTLE at `Kp`=32, one bad window, then good windows: `Kp` stays 32, `good_cnt` restarts, and the next halving occurs 4 good windows later.
- `rst` asserted for one cycle while in SETTLE with `Kp`=16: next cycle `Kp`=128, `state`=0, `locked`=0, and the window restarts (`win_done` 64 cycles later).
- KP_MAX=KP_MIN=8: after 4 good windows, ACQ goes directly to LOCK with `Kp`=8.
